// File: rtl/buscaminas_pkg.sv
// ============================================================================
// Module : buscaminas_pkg
// Brief  : Shared board constants, cell/board typedefs and reveal FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package buscaminas_pkg;

    localparam int         FILAS       = 8;
    localparam int         COLUMNAS    = 8;
    localparam logic [3:0] CELDA_BOMBA = 4'hF;

    typedef logic [3:0] celda_t;
    typedef celda_t [FILAS-1:0][COLUMNAS-1:0] tablero_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        POP     = 3'd2,
        VECINOS = 3'd3,
        FIN     = 3'd4
    } estado_t;

    // {row delta, column delta} as 4-bit two's complement; order N,NE,E,SE,S,SW,W,NW
    function automatic logic [7:0] delta_vecino(input logic [2:0] dir);
        logic [7:0] d;
        case (dir)
            3'd0:    d = {4'hF, 4'h0};
            3'd1:    d = {4'hF, 4'h1};
            3'd2:    d = {4'h0, 4'h1};
            3'd3:    d = {4'h1, 4'h1};
            3'd4:    d = {4'h1, 4'h0};
            3'd5:    d = {4'h1, 4'hF};
            3'd6:    d = {4'h0, 4'hF};
            default: d = {4'hF, 4'hF};
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cola_celdas.sv
// ============================================================================
// Module : cola_celdas
// Brief  : FIFO of cell indices awaiting neighbour expansion, synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cola_celdas #(
    parameter int PROFUNDIDAD = 64,
    parameter int ANCHO       = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic [ANCHO-1:0] dato,
    input  logic             pop,
    output logic [ANCHO-1:0] cabeza,
    output logic             vacia
);

    localparam int AW = $clog2(PROFUNDIDAD);

    logic [ANCHO-1:0] mem [PROFUNDIDAD];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cuenta;
    logic             push_ok;
    logic             pop_ok;

    assign vacia   = (cuenta == '0);
    assign push_ok = push && (cuenta != (AW+1)'(PROFUNDIDAD));
    assign pop_ok  = pop && !vacia;
    assign cabeza  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= dato;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cuenta <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cuenta <= cuenta + 1'b1;
                2'b01:   cuenta <= cuenta - 1'b1;
                default: cuenta <= cuenta;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/revelar_celdas.sv
// ============================================================================
// Module : revelar_celdas
// Brief  : Minesweeper cell reveal with zero-cell flood fill via a cell queue.
//          Optional REVELAR_TODO_EN: a bomb hit reveals the whole board.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module revelar_celdas
    import buscaminas_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0][7:0][3:0] matriz_bombas,
    input  logic [5:0]           numero_bombas,
    input  logic [2:0]           fila,
    input  logic [2:0]           columna,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 explosion,
    output logic                 ganador,
    output logic [7:0][7:0]      revelado,
    output logic [6:0]           num_revelados
);

    estado_t     estado;
    logic [2:0]  fila_sel;
    logic [2:0]  col_sel;
    logic [5:0]  actual;
    logic [2:0]  dir;
    logic [63:0] encolado;

    logic [7:0]  delta;
    logic [3:0]  nf;
    logic [3:0]  nc;
    logic        dentro;
    logic [5:0]  vidx;
    celda_t      vcelda;
    celda_t      scelda;
    logic        push;
    logic [5:0]  push_dato;
    logic        pop;
    logic [5:0]  cabeza;
    logic        vacia;

    assign busy = (estado == SEED) || (estado == POP) || (estado == VECINOS);
    assign done = (estado == FIN);

    // Bit 3 of the widened coordinate flags both -1 and 8, i.e. off the board
    always_comb begin
        delta  = delta_vecino(dir);
        nf     = {1'b0, actual[5:3]} + delta[7:4];
        nc     = {1'b0, actual[2:0]} + delta[3:0];
        dentro = !nf[3] && !nc[3];
        vidx   = {nf[2:0], nc[2:0]};
        vcelda = matriz_bombas[nf[2:0]][nc[2:0]];
        scelda = matriz_bombas[fila_sel][col_sel];
    end

    always_comb begin
        push      = 1'b0;
        push_dato = {fila_sel, col_sel};
        pop       = (estado == POP) && !vacia;
        if (estado == SEED) begin
            push = !revelado[fila_sel][col_sel] && (scelda == 4'd0)
                   && !encolado[{fila_sel, col_sel}];
        end else if (estado == VECINOS) begin
            push_dato = vidx;
            push      = dentro && !revelado[nf[2:0]][nc[2:0]] && (vcelda == 4'd0)
                        && !encolado[vidx];
        end
    end

    cola_celdas #(
        .PROFUNDIDAD (64),
        .ANCHO       (6)
    ) u_cola (
        .clk    (clk),
        .clear  (rst),
        .push   (push),
        .dato   (push_dato),
        .pop    (pop),
        .cabeza (cabeza),
        .vacia  (vacia)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado        <= IDLE;
            fila_sel      <= '0;
            col_sel       <= '0;
            actual        <= '0;
            dir           <= '0;
            explosion     <= 1'b0;
            ganador       <= 1'b0;
            revelado      <= '0;
            num_revelados <= '0;
            encolado      <= '0;
        end else begin
            if (push) begin
                encolado[push_dato] <= 1'b1;
            end
            case (estado)
                IDLE: begin
                    if (start && !explosion && !ganador) begin
                        fila_sel <= fila;
                        col_sel  <= columna;
                        estado   <= SEED;
                    end
                end
                SEED: begin
                    estado <= FIN;
                    if (!revelado[fila_sel][col_sel]) begin
                        if (scelda == CELDA_BOMBA) begin
                            explosion <= 1'b1;
`ifdef REVELAR_TODO_EN
                            revelado      <= '1;
                            num_revelados <= 7'd64;
`else
                            revelado[fila_sel][col_sel] <= 1'b1;
                            num_revelados               <= num_revelados + 7'd1;
`endif
                        end else begin
                            revelado[fila_sel][col_sel] <= 1'b1;
                            num_revelados               <= num_revelados + 7'd1;
                            if (scelda == 4'd0) begin
                                estado <= POP;
                            end
                        end
                    end
                end
                POP: begin
                    if (vacia) begin
                        estado <= FIN;
                    end else begin
                        actual <= cabeza;
                        dir    <= '0;
                        estado <= VECINOS;
                    end
                end
                VECINOS: begin
                    if (dentro && !revelado[nf[2:0]][nc[2:0]] && (vcelda != CELDA_BOMBA)) begin
                        revelado[nf[2:0]][nc[2:0]] <= 1'b1;
                        num_revelados              <= num_revelados + 7'd1;
                    end
                    dir <= dir + 3'd1;
                    if (dir == 3'd7) begin
                        estado <= POP;
                    end
                end
                FIN: begin
                    if (!explosion && (num_revelados == (7'd64 - {1'b0, numero_bombas}))) begin
                        ganador <= 1'b1;
                    end
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_revelar_celdas.sv
// ============================================================================
// Module : tb_revelar_celdas
// Brief  : Self-checking bench for revelar_celdas against a flood-fill model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_revelar_celdas;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0][7:0][3:0] matriz_bombas = '0;
    logic [5:0]           numero_bombas = 6'd1;
    logic [2:0]           fila = '0;
    logic [2:0]           columna = '0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 explosion;
    logic                 ganador;
    logic [7:0][7:0]      revelado;
    logic [6:0]           num_revelados;

    always #5 clk = ~clk;

    revelar_celdas dut (
        .clk           (clk),
        .rst           (rst),
        .matriz_bombas (matriz_bombas),
        .numero_bombas (numero_bombas),
        .fila          (fila),
        .columna       (columna),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .explosion     (explosion),
        .ganador       (ganador),
        .revelado      (revelado),
        .num_revelados (num_revelados)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] bombas = '0;
    logic [63:0] m_rev = '0;
    logic        m_expl = 1'b0;
    logic        m_gan = 1'b0;
    bit          model_valid = 1'b0;

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nombre, act, exp);
        end
    endtask

    function automatic int vecinas(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8) begin
                    if (bombas[(r + dr) * 8 + c + dc]) n++;
                end
            end
        end
        return n;
    endfunction

    function automatic int valor(input int idx);
        return bombas[idx] ? 15 : vecinas(idx / 8, idx % 8);
    endfunction

    task automatic cargar_tablero(input logic [63:0] b);
        bombas = b;
        numero_bombas = 6'($countones(b));
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                matriz_bombas[r][c] = 4'(valor(r * 8 + c));
            end
        end
    endtask

    // Reference: classic minesweeper reveal with breadth-first flood of zero cells
    task automatic model_reveal(input int f, input int c);
        int q[$];
        int idx;
        idx = f * 8 + c;
        if (m_rev[idx]) return;
        if (bombas[idx]) begin
            m_expl = 1'b1;
`ifdef REVELAR_TODO_EN
            m_rev = '1;
`else
            m_rev[idx] = 1'b1;
`endif
            return;
        end
        m_rev[idx] = 1'b1;
        if (valor(idx) == 0) q.push_back(idx);
        while (q.size() > 0) begin
            int x;
            x = q.pop_front();
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    int rr, cc, n;
                    rr = x / 8 + dr;
                    cc = x % 8 + dc;
                    n  = rr * 8 + cc;
                    if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                        if (!bombas[n] && !m_rev[n]) begin
                            m_rev[n] = 1'b1;
                            if (valor(n) == 0) q.push_back(n);
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("popcount", 64'(num_revelados), 64'($countones(revelado)));
        end
        if (model_valid && !rst) begin
            chk("revelado", revelado, m_rev);
            chk("num_revelados", 64'(num_revelados), 64'($countones(m_rev)));
            chk("explosion", 64'(explosion), 64'(m_expl));
            chk("ganador", 64'(ganador), 64'(m_gan));
            chk("idle_busy", 64'(busy), 64'd0);
        end
    end

    task automatic do_reset();
        model_valid = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_rev  = '0;
        m_expl = 1'b0;
        m_gan  = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_explosion", 64'(explosion), 64'd0);
        chk("rst_ganador", 64'(ganador), 64'd0);
        chk("rst_revelado", revelado, 64'd0);
        chk("rst_num", 64'(num_revelados), 64'd0);
        model_valid = 1'b1;
    endtask

    // lat = clock edges after the accepting edge until done is seen
    task automatic revelar(input int f, input int c, input int lim, input bit intruso, output int lat);
        bit ignorar;
        ignorar = m_expl || m_gan;
        lat = 0;
        @(posedge clk); #1;
        model_valid = 1'b0;
        fila    = 3'(f);
        columna = 3'(c);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (ignorar) begin
            model_valid = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("ignored_start_busy", 64'(busy), 64'd0);
                chk("ignored_start_done", 64'(done), 64'd0);
            end
            return;
        end
        @(negedge clk);
        chk("busy_rises", 64'(busy), 64'd1);
        model_reveal(f, c);
        while (!done && lat < lim) begin
            @(posedge clk);
            lat++;
            if (intruso && lat == 4) begin
                #1;
                fila    = 3'd0;
                columna = 3'd0;
                start   = 1'b1;
            end else if (intruso && lat == 5) begin
                #1;
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_busy_low", 64'(busy), 64'd0);
        start = 1'b0;
        if (!m_expl && $countones(m_rev) == 64 - int'(numero_bombas)) m_gan = 1'b1;
        @(posedge clk); #1;
        model_valid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [63:0] antes;
        logic [63:0] b;

        // Board A: single bomb at (0,0)
        cargar_tablero(64'h1);
        do_reset();

        revelar(0, 1, 700, 1'b0, lat);
        chk("count_cell_latency_le3", 64'(lat <= 3), 64'd1);
        chk("count_cell_revelado", revelado, 64'h2);
        chk("count_cell_num", 64'(num_revelados), 64'd1);

        antes = revelado;
        revelar(0, 1, 700, 1'b0, lat);
        chk("repeat_latency_le3", 64'(lat <= 3), 64'd1);
        chk("repeat_unchanged", revelado, antes);

        revelar(7, 7, 700, 1'b1, lat);
        chk("flood_revelado", revelado, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("flood_num", 64'(num_revelados), 64'd63);
        chk("flood_ganador", 64'(ganador), 64'd1);
        chk("flood_explosion", 64'(explosion), 64'd0);

        revelar(0, 0, 700, 1'b0, lat);
        chk("after_win_no_explosion", 64'(explosion), 64'd0);

        // Bomb hit
        do_reset();
        revelar(0, 0, 700, 1'b0, lat);
        chk("bomb_explosion", 64'(explosion), 64'd1);
        chk("bomb_latency_le3", 64'(lat <= 3), 64'd1);
`ifdef REVELAR_TODO_EN
        chk("bomb_revelado", revelado, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bomb_num", 64'(num_revelados), 64'd64);
`else
        chk("bomb_revelado", revelado, 64'h1);
        chk("bomb_num", 64'(num_revelados), 64'd1);
`endif
        revelar(3, 3, 700, 1'b0, lat);

        // Reset in the middle of an all-zero flood
        cargar_tablero(64'h0);
        numero_bombas = 6'd1;
        do_reset();
        model_valid = 1'b0;
        @(posedge clk); #1;
        fila = 3'd3; columna = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_flood_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_revelado", revelado, 64'd0);
        chk("midrst_num", 64'(num_revelados), 64'd0);
        chk("midrst_flags", 64'({explosion, ganador}), 64'd0);
        m_rev = '0; m_expl = 1'b0; m_gan = 1'b0;
        model_valid = 1'b1;
        revelar(3, 3, 700, 1'b0, lat);
        chk("zero_board_revelado", revelado, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("zero_board_latency", 64'(lat <= 578), 64'd1);
        chk("zero_board_ganador", 64'(ganador), 64'd0);

        // Corner flood, bomb at (7,0)
        cargar_tablero(64'h1 << 56);
        do_reset();
        revelar(0, 7, 700, 1'b0, lat);
        chk("corner_revelado", revelado, 64'hFEFF_FFFF_FFFF_FFFF);
        chk("corner_num", 64'(num_revelados), 64'd63);
        chk("corner_ganador", 64'(ganador), 64'd1);
        chk("corner_latency_le578", 64'(lat <= 578), 64'd1);

        // Random games
        for (int g = 0; g < 6; g++) begin
            int nb;
            b  = '0;
            nb = int'($urandom_range(1, 10));
            while ($countones(b) < nb) b[$urandom_range(0, 63)] = 1'b1;
            cargar_tablero(b);
            do_reset();
            for (int k = 0; k < 20 && !m_expl && !m_gan; k++) begin
                revelar(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 700, 1'b0, lat);
            end
        end

        model_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
